// File: rtl/adder_tree_pkg.sv
// Shared types and latency helpers for the 4-ary adder tree and its frame controller.
package adder_tree_pkg;

   localparam int WIDTH_DEF      = 17;
   localparam int INPUT_SIZE_DEF = 32;

   typedef logic signed [WIDTH_DEF-1:0] word_t;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } fsm_t;

   // Number of 4:1 reduction levels needed to fold input_size words to one.
   function automatic int tree_levels(input int input_size);
      return ($clog2(input_size) + 1) / 2;
   endfunction

   // Input register stage plus one stage per reduction level.
   function automatic int tree_lat(input int input_size);
      return tree_levels(input_size) + 1;
   endfunction

endpackage

// File: rtl/adderTree_1D_p4.sv
// Free-running pipelined 4-ary adder tree: registered inputs, then one
// registered 4:1 reduction per level. No reset; latency is tree_lat(INPUT_SIZE).
module adderTree_1D_p4
   import adder_tree_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int INPUT_SIZE = INPUT_SIZE_DEF
) (
   input  logic                    clk,
   input  logic signed [WIDTH-1:0] input_data [INPUT_SIZE],
   output logic signed [WIDTH-1:0] output_data
);

   localparam int LVL    = tree_levels(INPUT_SIZE);
   localparam int LEAVES = 1 << (2 * LVL);
   localparam int NODES  = (4 * LEAVES - 1) / 3;

   // All levels live in one flat array; level l starts at lvl_off(l).
   function automatic int lvl_off(input int l);
      int o;
      o = 0;
      for (int k = 0; k < l; k++) o += 1 << (2 * (LVL - k));
      return o;
   endfunction

   logic signed [WIDTH-1:0] leaf [LEAVES];
   logic signed [WIDTH-1:0] node [NODES];

   always_comb begin
      for (int i = 0; i < LEAVES; i++) leaf[i] = '0;
      for (int i = 0; i < INPUT_SIZE; i++) leaf[i] = input_data[i];
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LEAVES; i++) node[i] <= leaf[i];
      for (int l = 1; l <= LVL; l++) begin
         for (int i = 0; i < (1 << (2 * (LVL - l))); i++) begin
            node[lvl_off(l) + i] <= node[lvl_off(l-1) + 4*i]     + node[lvl_off(l-1) + 4*i + 1]
                                  + node[lvl_off(l-1) + 4*i + 2] + node[lvl_off(l-1) + 4*i + 3];
         end
      end
   end

   assign output_data = node[NODES-1];

endmodule

// File: rtl/result_fifo.sv
// First-word-fall-through result FIFO with synchronous reset and occupancy count.
// Push and pop may coincide at any occupancy, including full.
module result_fifo #(
   parameter  int WIDTH = 17,
   parameter  int DEPTH = 4,
   localparam int CNTW  = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] head,
   output logic             head_valid,
   output logic [CNTW-1:0]  count
);

   localparam int PTRW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTRW-1:0]  rd_ptr;
   logic [PTRW-1:0]  wr_ptr;
   logic             pop;

   function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
      return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head_valid = (count != '0);
   assign head       = head_valid ? mem[rd_ptr] : '0;
   assign pop        = pop_ready && head_valid;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/adder_tree_frame_ctrl.sv
// Frame collector and result back end for the free-running adder tree. Launches
// a frame only when a FIFO slot is reserved for its sum, so no result is lost.
module adder_tree_frame_ctrl
   import adder_tree_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int INPUT_SIZE = INPUT_SIZE_DEF,
   parameter int RES_DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [WIDTH-1:0] in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [WIDTH-1:0] frame_data [INPUT_SIZE],
   input  logic signed [WIDTH-1:0] tree_sum,
   output logic signed [WIDTH-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int TREE_LAT = tree_lat(INPUT_SIZE);
   localparam int WCW      = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
   localparam int CNTW     = $clog2(RES_DEPTH + 1);
   localparam int CRW      = $clog2(RES_DEPTH + TREE_LAT + 2);
   localparam logic [WCW-1:0] WC_LAST = WCW'(INPUT_SIZE - 1);

   fsm_t                    state;
   logic [WCW-1:0]          wc;
   logic signed [WIDTH-1:0] shadow [INPUT_SIZE];
   // Bit 0 is set on the launch edge; the top bit marks the cycle tree_sum is valid.
   logic [TREE_LAT:0]       vld_pipe;
   logic [CNTW-1:0]         fifo_count;
   logic [CRW-1:0]          inflight;
   logic                    credit_ok;
   logic                    accept;
   logic                    launch;
   logic                    capture;

   // Credit uses only registered counts, so out_ready never reaches in_ready.
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= TREE_LAT; i++) inflight = inflight + CRW'(vld_pipe[i]);
   end

   assign credit_ok = (CRW'(fifo_count) + inflight) < CRW'(RES_DEPTH);
   assign in_ready  = (state == COLLECT) && !reset;
   assign accept    = in_valid && in_ready;
   assign launch    = ((state == COLLECT) && accept && (wc == WC_LAST) && credit_ok)
                   || ((state == HOLD) && credit_ok);
   assign capture   = vld_pipe[TREE_LAT];

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= COLLECT;
         wc       <= '0;
         vld_pipe <= '0;
         for (int i = 0; i < INPUT_SIZE; i++) begin
            shadow[i]     <= '0;
            frame_data[i] <= '0;
         end
      end else begin
         vld_pipe <= {vld_pipe[TREE_LAT-1:0], launch};
         if (state == COLLECT) begin
            if (accept) begin
               if (wc == WC_LAST) begin
                  if (credit_ok) begin
                     for (int i = 0; i < INPUT_SIZE - 1; i++) frame_data[i] <= shadow[i];
                     frame_data[INPUT_SIZE-1] <= in_data;
                     wc <= '0;
                  end else begin
                     shadow[INPUT_SIZE-1] <= in_data;
                     state <= HOLD;
                  end
               end else begin
                  shadow[wc] <= in_data;
                  wc <= wc + 1'b1;
               end
            end
         end else if (credit_ok) begin
            for (int i = 0; i < INPUT_SIZE; i++) frame_data[i] <= shadow[i];
            wc    <= '0;
            state <= COLLECT;
         end
      end
   end

   result_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (RES_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (capture),
      .push_data  (tree_sum),
      .pop_ready  (out_ready),
      .head       (out_data),
      .head_valid (out_valid),
      .count      (fifo_count)
   );

endmodule

// File: tb/tb_adder_tree_frame_ctrl.sv
// Bench for adder_tree_frame_ctrl wired to adderTree_1D_p4; expected sums come
// from plain integer addition of each frame's words, kept in an ordered queue.
module tb_adder_tree_frame_ctrl;
   import adder_tree_pkg::*;

   localparam int W         = 17;
   localparam int N         = 32;
   localparam int RES_DEPTH = 4;
   localparam int TL        = 4;  // ceil(clog2(32)/2) + 1

   logic              clk = 1'b0;
   logic              reset;
   logic [W-1:0]      in_data;
   logic              in_valid;
   logic              in_ready;
   logic signed [W-1:0] frame_data [N];
   logic signed [W-1:0] tree_sum;
   logic signed [W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   int           n_assert = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   int           stalls   = 0;
   bit           rand_ready = 1'b0;
   logic [W-1:0] exp_q [$];
   int           rx_cyc_q [$];
   logic [W-1:0] last_data = '0;

   always #5 clk = ~clk;

   adder_tree_frame_ctrl #(.WIDTH(W), .INPUT_SIZE(N), .RES_DEPTH(RES_DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .frame_data (frame_data),
      .tree_sum   (tree_sum),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   adderTree_1D_p4 #(.WIDTH(W), .INPUT_SIZE(N)) u_tree (
      .clk         (clk),
      .input_data  (frame_data),
      .output_data (tree_sum)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model_sum(input logic [W-1:0] fr [N]);
      int          s;
      logic [31:0] u;
      s = 0;
      for (int i = 0; i < N; i++) s += int'($signed(fr[i]));
      u = s;
      return u[W-1:0];
   endfunction

   // One clock: score the pop that the coming edge performs, then advance.
   task automatic tick();
      logic [W-1:0] e;
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("frame_sum", 32'($unsigned(out_data)), 32'(e));
         end
         rx_cyc_q.push_back(cyc);
         last_data = out_data;
      end
      if (!reset && dut.capture)
         check("fifo_overflow", (dut.fifo_count == RES_DEPTH && !out_ready) ? 32'd1 : 32'd0, 32'd0);
      @(posedge clk);
      cyc++;
      #2;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_word(input logic [W-1:0] w);
      bit acc;
      acc      = 1'b0;
      in_data  = w;
      in_valid = 1'b1;
      for (int t = 0; t < 400; t++) begin
         acc = in_ready;
         tick();
         if (acc) break;
         stalls++;
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [W-1:0] fr [N], input int max_gap);
      for (int i = 0; i < N; i++) begin
         send_word(fr[i]);
         if (i != N - 1) repeat ($urandom_range(0, max_gap)) tick();
      end
      exp_q.push_back(model_sum(fr));
   endtask

   task automatic drain(input int budget);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < budget) begin
         tick();
         t++;
      end
      check("drain_timeout", exp_q.size(), 32'd0);
      repeat (TL + 4) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] fr [N];
      logic [W-1:0] orv;
      int           a;

      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      out_ready = 1'b0;
      repeat (3) tick();

      // Reset state
      check("reset_in_ready", in_ready, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", 32'($unsigned(out_data)), 0);
      orv = '0;
      for (int i = 0; i < N; i++) orv |= frame_data[i];
      check("reset_frame_data", orv, 0);
      reset = 1'b0;
      #1;
      check("in_ready_after_reset", in_ready, 1);
      out_ready = 1'b1;

      // Basic sum 1..32, latency and word placement
      for (int i = 0; i < N; i++) fr[i] = W'(i + 1);
      rx_cyc_q.delete();
      send_frame(fr, 0);
      a = cyc;
      check("frame_word0", 32'($unsigned(frame_data[0])), 1);
      check("frame_word1", 32'($unsigned(frame_data[1])), 2);
      check("frame_word30", 32'($unsigned(frame_data[N-2])), N - 1);
      check("frame_word31", 32'($unsigned(frame_data[N-1])), N);
      drain(100);
      check("basic_count", rx_cyc_q.size(), 1);
      check("basic_sum", last_data, 528);
      check("basic_latency", rx_cyc_q[0] - a, TL + 1);

      // Signed: four repeats of 1..8, final word -8
      for (int i = 0; i < N; i++) fr[i] = W'((i % 8) + 1);
      fr[N-1] = 17'h1FFF8;
      rx_cyc_q.delete();
      send_frame(fr, 1);
      drain(100);
      check("signed_count", rx_cyc_q.size(), 1);
      check("signed_sum", last_data, 128);

      // Back-to-back frames with no idle cycle
      rx_cyc_q.delete();
      stalls = 0;
      for (int i = 0; i < N; i++) fr[i] = W'(1);
      send_frame(fr, 0);
      for (int i = 0; i < N; i++) fr[i] = W'(2);
      send_word(fr[0]);
      check("frame_stable_until_launch", 32'($unsigned(frame_data[0])), 1);
      for (int i = 1; i < N; i++) send_word(fr[i]);
      exp_q.push_back(model_sum(fr));
      drain(100);
      check("b2b_count", rx_cyc_q.size(), 2);
      check("b2b_spacing", rx_cyc_q[1] - rx_cyc_q[0], N);
      check("b2b_no_stall", stalls, 0);
      check("b2b_last_sum", last_data, 64);

      // Backpressure: five frames into a four-deep result store
      out_ready = 1'b0;
      rx_cyc_q.delete();
      for (int f = 0; f < 5; f++) begin
         for (int i = 0; i < N; i++) fr[i] = W'($urandom());
         send_frame(fr, 0);
      end
      repeat (TL + 4) tick();
      check("bp_hold_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_buffered", 32'(dut.fifo_count), 4);
      check("bp_none_popped", rx_cyc_q.size(), 0);
      out_ready = 1'b1;
      drain(200);
      check("bp_drained_count", rx_cyc_q.size(), 5);
      check("bp_in_ready_back", in_ready, 1);

      // Modulo wrap
      for (int i = 0; i < N; i++) fr[i] = 17'h0FFFF;
      rx_cyc_q.delete();
      send_frame(fr, 0);
      drain(100);
      check("wrap_sum", last_data, 17'h1FFE0);

      // Random data, random gaps, random downstream readiness
      rx_cyc_q.delete();
      rand_ready = 1'b1;
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < N; i++) fr[i] = W'($urandom());
         send_frame(fr, 2);
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      drain(600);
      check("random_count", rx_cyc_q.size(), 6);

      // Reset in the middle of a frame
      rx_cyc_q.delete();
      for (int i = 0; i < 10; i++) send_word(W'($urandom()));
      reset = 1'b1;
      tick();
      check("midreset_in_ready", in_ready, 0);
      tick();
      reset = 1'b0;
      #1;
      check("midreset_out_valid", out_valid, 0);
      for (int i = 0; i < N; i++) fr[i] = W'(2);
      send_frame(fr, 0);
      drain(100);
      repeat (10) tick();
      check("midreset_count", rx_cyc_q.size(), 1);
      check("midreset_sum", last_data, 64);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
